// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, the data
// memory window and the enable/disable levels.
package dmem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int DMEM_BASE_ADDR = 1024;
    localparam int DMEM_BYTES     = 64;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant. last_grant resets to 1, so port 0 wins the
// first tie; it only moves when the grant is actually accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) gnt_id = ~last_grant;
        else              gnt_id = req[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     last_grant <= 1'b1;
        else if (accept && gnt_valid) last_grant <= gnt_id;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the
// debug/DMA loader (port 1): IDLE -> ACCESS (WAIT_CYCLES) -> RESP, or IDLE -> RESP on a fault.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int MEM_BYTES   = DMEM_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ready0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ready1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LO  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_HI  = ADDR_W'(BASE_ADDR + MEM_BYTES - 4);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_port;
    logic              lat_we;
    logic              lat_fault;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] resp_data;

    logic              idle;
    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_fault;

    assign idle = (state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1, req0}),
        .accept    (idle),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Only the granted port's operands are looked at, so the other port may wiggle freely.
    always_comb begin
        sel_we    = gnt_id ? we1    : we0;
        sel_addr  = gnt_id ? addr1  : addr0;
        sel_wdata = gnt_id ? wdata1 : wdata0;
        sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr < ADDR_LO) || (sel_addr > ADDR_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_fault <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        lat_port  <= gnt_id;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_fault <= sel_fault;
                        resp_data <= '0;
                        if (sel_fault) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        resp_data <= lat_we ? '0 : mem_rdata;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes are pure decodes of registered state so an async reset
    // drops MemWrite at once, before the next edge could commit a write.
    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        MemRead     = DISABLE;
        MemWrite    = DISABLE;
        if (state == ST_ACCESS) begin
            mem_address = lat_addr;
            mem_wdata   = lat_wdata;
            MemRead     = ~lat_we;
            MemWrite    = lat_we && (cnt == 4'd0);
        end
    end

    always_comb begin
        ready0 = (state == ST_RESP) && !lat_port;
        ready1 = (state == ST_RESP) &&  lat_port;
        rdata0 = ready0 ? resp_data : '0;
        rdata1 = ready1 ? resp_data : '0;
        err0   = ready0 && lat_fault;
        err1   = ready1 && lat_fault;
    end

    assign stall = req0 & ~ready0;
    assign busy  = ~idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued as each
// request is issued and popped when a ready pulse appears.
module tb_dmem_arbiter;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1, mem_address, mem_wdata, mem_rdata;
    logic        ready0, ready1, err0, err1, MemRead, MemWrite, stall, busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC), .BASE_ADDR(1024), .MEM_BYTES(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ready0(ready0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ready1(ready1), .err1(err1),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy)
    );

    // Memory model: 16 words at 1024..1087, combinational read.
    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h1000_0000 : (32'hA000_0000 | 32'(i));
    endfunction

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        init_done = 1'b0;
    logic        in_win;
    assign in_win    = (mem_address >= 32'd1024) && (mem_address < 32'd1088);
    assign mem_rdata = in_win ? mem[mem_address[5:2]] : '0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (MemWrite && in_win) begin
            mem[mem_address[5:2]] <= mem_wdata;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   rd_cyc = 0, wr_cyc = 0;
    logic pr0 = 1'b0, pr1 = 1'b0;

    always @(negedge clk) begin
        if (MemRead)  rd_cyc++;
        if (MemWrite) wr_cyc++;
        if (ready0 || ready1) begin
            chk("both_rdy", 64'(ready0 & ready1), 64'd0);
            chk("pulse_len", 64'((ready0 & pr0) | (ready1 & pr1)), 64'd0);
            chk("other_quiet", ready0 ? {31'd0, err1, rdata1} : {31'd0, err0, rdata0}, 64'd0);
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("resp_port", 64'(ready1), 64'(mon_e.port));
                chk("resp_rdata", 64'(ready1 ? rdata1 : rdata0), 64'(mon_e.rdata));
                chk("resp_err", 64'(ready1 ? err1 : err0), 64'(mon_e.err));
            end
        end
        pr0 = ready0;
        pr1 = ready1;
    end

    task automatic drive(input int port, input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
        else           begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic expect_resp(input int port, input logic we, input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        exp_t e;
        e.port  = port[0];
        e.err   = exp_err;
        e.rdata = (exp_err || we) ? 32'd0 : ref_mem[a[5:2]];
        if (we && !exp_err) ref_mem[a[5:2]] = d;
        sbq.push_back(e);
    endtask

    task automatic wait_ready(input int port, output int n, output logic got);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if ((port == 0) ? ready0 : ready1) got = 1'b1;
            else begin
                if (port == 0) chk("stall_wait", 64'(stall), 64'd1);
                n++;
            end
        end
        chk("ready_timeout", 64'(got), 64'd1);
    endtask

    task automatic xact(input int port, input logic we, input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        int   rd0, wr0, n;
        logic got;
        expect_resp(port, we, a, d, exp_err);
        @(posedge clk); #1;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        drive(port, 1'b1, we, a, d);
        wait_ready(port, n, got);
        chk("latency", 64'(n), exp_err ? 64'd1 : 64'(WC + 1));
        if (port == 0) chk("stall_at_rdy", 64'(stall), 64'd0);
        chk("rd_cycles", 64'(rd_cyc - rd0), (we || exp_err) ? 64'd0 : 64'(WC));
        chk("wr_cycles", 64'(wr_cyc - wr0), (we && !exp_err) ? 64'd1 : 64'd0);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int   n, events, rd0, wr0;
        logic got;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (3) @(posedge clk);
        init_done = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 64'(ready0), 64'd0);
        chk("rst_ready1", 64'(ready1), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({MemRead, MemWrite}), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst = 1'b1;

        // Single read, then store/load round trip
        xact(0, 1'b0, 32'd1024, 32'd0, 1'b0);
        xact(0, 1'b1, 32'd1036, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 32'd1036, 32'd0, 1'b0);
        chk("mem_1036", 64'(mem[3]), 64'h0000_0000_DEAD_BEEF);

        // Reset in the write cycle of a store: no write, no ready
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'd1028, 32'h5555_AAAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_mw_pre", 64'(MemWrite), 64'd1);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("abort_mw", 64'(MemWrite), 64'd0);
        chk("abort_outs", 64'({MemRead, busy, ready0, ready1, err0, stall}), 64'd0);
        chk("abort_addr", 64'(mem_address), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_noready", 64'({ready0, ready1}), 64'd0);
        end
        chk("abort_mem", 64'(mem[1]), 64'(ref_mem[1]));
        rst = 1'b1;

        // Faults on port 1, then an in-window boundary access
        xact(1, 1'b0, 32'd1026, 32'd0, 1'b1);
        xact(1, 1'b0, 32'd1020, 32'd0, 1'b1);
        xact(1, 1'b0, 32'd1088, 32'd0, 1'b1);
        xact(1, 1'b1, 32'd1026, 32'h1234_5678, 1'b1);
        xact(1, 1'b0, 32'd1084, 32'd0, 1'b0);

        // Contention: both held through four transactions, last grant was port 1
        expect_resp(0, 1'b0, 32'd1024, 32'd0, 1'b0);
        expect_resp(1, 1'b0, 32'd1028, 32'd0, 1'b0);
        expect_resp(0, 1'b0, 32'd1024, 32'd0, 1'b0);
        expect_resp(1, 1'b0, 32'd1028, 32'd0, 1'b0);
        @(posedge clk); #1;
        rd0 = rd_cyc;
        drive(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd1028, 32'd0);
        events = 0;
        n = 0;
        while (events < 4 && n < 80) begin
            @(negedge clk);
            if (ready0 || ready1) events++;
            n++;
        end
        chk("cont_events", 64'(events), 64'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("cont_rd_cycles", 64'(rd_cyc - rd0), 64'(4 * WC));
        chk("cont_sb_drained", 64'(sbq.size()), 64'd0);

        // req1 dropped during ACCESS of a store
        expect_resp(1, 1'b1, 32'd1032, 32'hCAFE_F00D, 1'b0);
        @(posedge clk); #1;
        wr0 = wr_cyc;
        drive(1, 1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("drop_busy", 64'(busy), 64'd1);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_ready(1, n, got);
        chk("drop_wr_cycles", 64'(wr_cyc - wr0), 64'd1);
        @(posedge clk); #1;
        xact(0, 1'b0, 32'd1032, 32'd0, 1'b0);
        chk("mem_1032", 64'(mem[2]), 64'h0000_0000_CAFE_F00D);

        repeat (2) @(posedge clk);
        chk("final_sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
